// File: rtl/gnn_out_collector.sv
// Capture-and-drain collector for the eight gnn node results: latches each result on its
// first ready flag, then streams all eight slots in index order over one valid/ready port.
module gnn_out_collector #(
    parameter int DATA_W      = 17,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] out0_node0,
    input  logic [DATA_W-1:0] out1_node0,
    input  logic [DATA_W-1:0] out0_node1,
    input  logic [DATA_W-1:0] out1_node1,
    input  logic [DATA_W-1:0] out0_node2,
    input  logic [DATA_W-1:0] out1_node2,
    input  logic [DATA_W-1:0] out0_node3,
    input  logic [DATA_W-1:0] out1_node3,
    input  logic              out0_ready_node0,
    input  logic              out1_ready_node0,
    input  logic              out0_ready_node1,
    input  logic              out1_ready_node1,
    input  logic              out0_ready_node2,
    input  logic              out1_ready_node2,
    input  logic              out0_ready_node3,
    input  logic              out1_ready_node3,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_idx,
    output logic              m_miss,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [1:0]        dbg_state
);

    // Drain handshake: a beat transfers on a rising edge where m_valid && m_ready; m_valid
    // depends only on registered state, and all m_* outputs hold while m_ready is low.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [7:0]        mask_q, mask_d;
    logic [DATA_W-1:0] slot_q [8];
    logic [DATA_W-1:0] slot_d [8];
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    // Slot index is node*2 + k, with k=0 for out0 and k=1 for out1.
    logic [DATA_W-1:0] din [8];
    logic [7:0]        flag;

    assign din[0] = out0_node0;
    assign din[1] = out1_node0;
    assign din[2] = out0_node1;
    assign din[3] = out1_node1;
    assign din[4] = out0_node2;
    assign din[5] = out1_node2;
    assign din[6] = out0_node3;
    assign din[7] = out1_node3;

    assign flag = {out1_ready_node3, out0_ready_node3, out1_ready_node2, out0_ready_node2,
                   out1_ready_node1, out0_ready_node1, out1_ready_node0, out0_ready_node0};

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d    = '0;
                    cnt_d     = '0;
                    ptr_d     = '0;
                    timeout_d = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        slot_d[i] = '0;
                    end
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < 8; i++) begin
                    if (flag[i] && !mask_q[i]) begin
                        mask_d[i] = 1'b1;
                        slot_d[i] = din[i];
                    end
                end
                cnt_d = cnt_q + 16'd1;
                // Completion wins over a coincident timeout, so a full mask never flags timeout.
                if (&mask_d) begin
                    state_d = S_DRAIN;
                    ptr_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DRAIN;
                    ptr_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    ptr_d = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign m_valid   = (state_q == S_DRAIN);
    assign m_data    = m_valid ? slot_q[ptr_q] : '0;
    assign m_idx     = ptr_q;
    assign m_miss    = m_valid && !mask_q[ptr_q];
    assign m_last    = m_valid && (ptr_q == 3'd7);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: doc/gnn_out_collector.md
# gnn_out_collector

Capture-and-drain block on the output side of the `gnn` datapath. It receives the eight 17-bit node results (`out0`/`out1` for nodes 0–3) and their individual ready flags, and latches each result the first time its flag is seen. It then streams the eight results in fixed order over a single valid/ready port to the downstream checker or host. A timeout bounds the capture window so that a missing result cannot hang the drain.

## Interface
- `DATA_W`, default 17: width of each result word.
- `TIMEOUT_CYC`, default 255: maximum number of cycles spent in CAPTURE, range 2–65535.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: arms a capture; sampled only in IDLE.
- `out0_node0` … `out1_node3`, input, DATA_W each: the eight result words from `gnn`.
- `out0_ready_node0` … `out1_ready_node3`, input, 1 each: per-result ready flags from `gnn`. A flag may stay high for many cycles.
- `m_data`, output, DATA_W: current drained word.
- `m_idx`, output, 3: slot index, equal to node*2 + k, where k=0 for `out0` and k=1 for `out1`.
- `m_miss`, output, 1: the current slot was never captured; `m_data` is 0 in that case.
- `m_valid`, output, 1: a drain beat is offered.
- `m_last`, output, 1: the current beat is slot 7.
- `m_ready`, input, 1: downstream accepts the beat.
- `busy`, output, 1: high in CAPTURE or DRAIN.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.
- `timeout`, output, 1: sticky flag, set when CAPTURE ended by timeout; cleared by the next accepted `start`.

## Operation
- State machine: IDLE → CAPTURE → DRAIN → IDLE.
- IDLE:
  - `start`=1 clears the capture mask, all slot registers (to 0), the cycle counter, and `timeout`.
  - The block enters CAPTURE on the next cycle.
  - Ready flags are ignored in IDLE, including in the `start` cycle.
- CAPTURE:
  - Each cycle, every slot whose ready flag is 1 and whose mask bit is 0 latches its input word and sets its mask bit.
  - Any number of slots may capture in the same cycle.
  - A slot whose mask bit is already set ignores its flag; the first captured value is kept.
  - The cycle counter increments every CAPTURE cycle.
  - Exit to DRAIN on the edge where the next mask value is all ones, or where counter == TIMEOUT_CYC−1.
  - On a timeout exit with an incomplete mask, `timeout` is set. Captures occurring on the exit edge are still kept.
- DRAIN:
  - The slot pointer starts at 0.
  - `m_valid`=1, `m_idx`=pointer, `m_data`=slot[pointer], `m_miss`=!mask[pointer], `m_last`=(pointer==7).
  - The pointer advances only on `m_valid && m_ready`.
  - While `m_ready`=0, all `m_*` outputs hold stable.
  - On the handshake of slot 7, the block returns to IDLE and `done` pulses on the following cycle.
- `start` is ignored in CAPTURE and DRAIN.
- No arithmetic is applied to the data; words pass through bit-exact at DATA_W.

## Timing
- Reset (`rst_n`=0 at an edge) returns the block to IDLE.
  - Outputs after reset: `m_valid`=0, `m_data`=0, `m_idx`=0, `m_miss`=0, `m_last`=0, `busy`=0, `done`=0, `timeout`=0.
  - Internal state after reset: mask=0, slots=0, counter=0.
  - Reset takes effect mid-capture or mid-drain with no partial beat.
- `start` sampled at edge t gives CAPTURE and `busy`=1 from t+1.
- A flag sampled high at edge t in CAPTURE updates its mask bit and slot at t+1.
- If the last missing slot is captured at edge t, `m_valid`=1 from t+1, `m_idx`=0.
- With `m_ready` held at 1, the drain takes exactly 8 cycles, one beat per cycle.
- Final handshake at edge t: `m_valid`=0 and `busy`=0 from t+1; `done`=1 during cycle t+1 only.
- `start` is accepted again from cycle t+1 (the cycle in which `done` is high).
- The maximum CAPTURE duration is TIMEOUT_CYC cycles.
- All outputs are registered or decoded directly from registers; there is no combinational path from `m_ready` to `m_valid`.

## Test plan
- **Simultaneous capture:** `start`, then all eight flags raised in one cycle, with `out0_node0`=17'h00012 … `out1_node3`=17'h1FFF0 and `m_ready`=1.
  - Required: beats idx 0..7 on 8 consecutive cycles with exact values and `m_miss`=0.
  - Required: `m_last` only on idx 7, `done` pulses the cycle after, `timeout`=0.
- **Staggered flags with backpressure:** flags raised one per cycle in reverse order (slot 7 first); `m_ready` toggles 1,0,0,1….
  - Required: drain starts the cycle after slot 0 is captured.
  - Required: order is still 0..7, and `m_data`/`m_idx` hold while `m_ready`=0.
- **First value wins:** slot 3 flag held high while its input changes from 17'h00005 to 17'h0000A.
  - Required: idx 3 drains 17'h00005.
- **Timeout:** TIMEOUT_CYC=16; only node 0 flags rise.
  - Required: drain begins 16 cycles after CAPTURE entry.
  - Required: slots 2–7 show `m_data`=0 with `m_miss`=1; `timeout`=1 until the next `start`.
- **Reset mid-drain:** `rst_n`=0 for one cycle during beat idx 4.
  - Required: the next cycle shows all outputs at reset values and the block in IDLE.
  - Required: flags asserted afterwards with no `start` produce no beats.
- **Ignored start:** `start`=1 pulses during CAPTURE and during DRAIN.
  - Required: no effect on mask, pointer, counter, or `timeout`.
